// File: rtl/zynq_ser_tx_framer.sv
// rtl/zynq_ser_tx_framer.sv - 7:1 LVDS word-level transmit framer (HOLD/TRAIN/RUN, input FIFO); optional TX_PRBS_TRAIN_EN
module zynq_ser_tx_framer #(
    parameter int              N                = 1,
    parameter int              D                = 4,
    parameter logic [6:0]      CLK_PATT         = 7'b1100011,
    parameter logic [6:0]      TRAIN_PATT       = 7'b0011010,
    parameter logic [6:0]      IDLE_WORD        = 7'b0000000,
    parameter int              TRAIN_LEN        = 256,
    parameter int              HOLD_LEN         = 16,
    parameter int              FIFO_DEPTH       = 4,
    parameter logic [N*D-1:0]  TX_SWAP_MASK     = {N*D{1'b0}},
    parameter logic [N-1:0]    TX_CLK_SWAP_MASK = {N{1'b0}}
) (
    input  logic               gclk,
    input  logic               resetn,
    input  logic               train_req,
    input  logic [N*D*7-1:0]   s_dat,
    input  logic               s_valid,
    output logic               s_ready,
    output logic [N*D*7-1:0]   tx_dat,
    output logic [N*7-1:0]     tx_clk,
    output logic [1:0]         link_state,
    output logic [15:0]        underrun_cnt
);
    localparam int LW = N * D * 7;
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // Per-lane inversion pattern for P/N swapped data lanes.
    function automatic logic [LW-1:0] f_dat_inv();
        logic [LW-1:0] v;
        v = '0;
        for (int k = 0; k < N * D; k++) v[7*k +: 7] = {7{TX_SWAP_MASK[k]}};
        return v;
    endfunction

    // Clock-lane words with swapped lanes already inverted.
    function automatic logic [N*7-1:0] f_clk_word();
        logic [N*7-1:0] v;
        for (int k = 0; k < N; k++) v[7*k +: 7] = CLK_PATT ^ {7{TX_CLK_SWAP_MASK[k]}};
        return v;
    endfunction

    localparam logic [LW-1:0]  DAT_INV   = f_dat_inv();
    localparam logic [N*7-1:0] CLK_WORD  = f_clk_word();
    localparam logic [LW-1:0]  TRAIN_RST = {(N*D){TRAIN_PATT}} ^ DAT_INV;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    logic [15:0]     train_cnt_q, train_cnt_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            s_ready_q;
    logic [LW-1:0]   tx_dat_q, tx_word_d;
    logic [N*7-1:0]  tx_clk_q;
    logic [15:0]     ur_q, ur_d;
    logic [LW-1:0]   mem_q [FIFO_DEPTH];
    logic            push, pop;

`ifdef TX_PRBS_TRAIN_EN
    logic [6:0]      prbs_q, prbs_d;

    // Advance PRBS-7 (x^7+x^6+1) by one 7-bit word; the first new bit lands in bit 6.
    function automatic logic [6:0] prbs_step7(input logic [6:0] s);
        logic [6:0] r;
        r = s;
        for (int i = 0; i < 7; i++) r = {r[5:0], r[6] ^ r[5]};
        return r;
    endfunction
`endif

    // Registered s_ready is exactly !full, so only accepted words are pushed.
    assign push = s_valid & s_ready_q;

    // Link state machine: HOLD then TRAIN then RUN, with retraining on request.
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        train_cnt_d = train_cnt_q;
        case (state_q)
            ST_HOLD: begin
                if (hold_cnt_q == 8'(HOLD_LEN - 1)) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            ST_TRAIN: begin
                if (train_req) train_cnt_d = '0;
                else if (train_cnt_q == 16'(TRAIN_LEN - 1)) state_d = ST_RUN;
                else train_cnt_d = train_cnt_q + 16'd1;
            end
            ST_RUN: begin
                if (train_req) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    // Output word selection keyed on the next state so tx_dat and link_state change together.
    always_comb begin
        pop       = (state_d == ST_RUN) && (count_q != '0);
        tx_word_d = {(N*D){TRAIN_PATT}};
        ur_d      = ur_q;
`ifdef TX_PRBS_TRAIN_EN
        prbs_d = prbs_q;
        if (state_d == ST_TRAIN) begin
            prbs_d    = (state_q != ST_TRAIN) ? prbs_step7(7'h7F) : prbs_step7(prbs_q);
            tx_word_d = {(N*D){prbs_d}};
        end
`endif
        if (state_d == ST_RUN) begin
            if (pop) begin
                tx_word_d = mem_q[rd_ptr_q];
            end else begin
                tx_word_d = {(N*D){IDLE_WORD}};
                if (ur_q != 16'hFFFF) ur_d = ur_q + 16'd1;
            end
        end
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // State, counters, FIFO pointers and registered outputs.
    always_ff @(posedge gclk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= '0;
            train_cnt_q <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            s_ready_q   <= 1'b0;
            tx_dat_q    <= TRAIN_RST;
            tx_clk_q    <= CLK_WORD;
            ur_q        <= '0;
`ifdef TX_PRBS_TRAIN_EN
            prbs_q      <= 7'h7F;
`endif
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            train_cnt_q <= train_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            s_ready_q   <= (count_d != CW'(FIFO_DEPTH));
            tx_dat_q    <= tx_word_d ^ DAT_INV;
            tx_clk_q    <= CLK_WORD;
            ur_q        <= ur_d;
`ifdef TX_PRBS_TRAIN_EN
            prbs_q      <= prbs_d;
`endif
        end
    end

    // FIFO storage; emptiness is tracked by the pointers, so no reset is needed here.
    always_ff @(posedge gclk) begin
        if (push) mem_q[wr_ptr_q] <= s_dat;
    end

    assign s_ready      = s_ready_q;
    assign tx_dat       = tx_dat_q;
    assign tx_clk       = tx_clk_q;
    assign link_state   = state_q;
    assign underrun_cnt = ur_q;
endmodule

// File: doc/zynq_ser_tx_framer.md
# zynq_ser_tx_framer

Word-level transmit framer for the 7:1 LVDS link, the transmitting end of the 1:7 DDR deserializer path. It runs in the pixel-clock domain and produces one 7-bit word per data lane plus the clock-lane word every cycle, ready for the 7:1 OSERDES stage. After reset, or on request, it sends a fixed training sequence so the far-end receiver can lock its MMCM, phase and bitslip alignment. It then streams buffered user data, substituting idle words when the buffer runs dry.

## Interface
Parameters:
- `N`, 1: number of channels.
- `D`, 4: data lanes per channel.
- `CLK_PATT`, 7'b1100011: clock-lane word, sent every cycle in every state.
- `TRAIN_PATT`, 7'b0011010: data-lane training word.
- `IDLE_WORD`, 7'b0000000: data-lane word sent when the FIFO is empty in RUN.
- `TRAIN_LEN`, 256: number of TRAIN cycles, range 1..65535.
- `HOLD_LEN`, 16: number of HOLD cycles after reset, range 1..255.
- `FIFO_DEPTH`, 4: input FIFO entries; must be a power of two, at least 2.
- `TX_SWAP_MASK`, {N*D{1'b0}}: per data lane, 1 means the P/N pair is swapped and the lane's word is inverted.
- `TX_CLK_SWAP_MASK`, {N{1'b0}}: the same, per clock lane.

Ports:
- `gclk`, in, 1: pixel clock; the only clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `train_req`, in, 1: level; (re)start training.
- `s_dat`, in, N\*D\*7: input words; lane k occupies [7k+6:7k].
- `s_valid`, in, 1: `s_dat` is valid.
- `s_ready`, out, 1: the FIFO can accept a word.
- `tx_dat`, out, N\*D\*7: serializer data words; bit 6 is the first serial bit.
- `tx_clk`, out, N\*7: serializer clock-lane words.
- `link_state`, out, 2: current state; 0 = HOLD, 1 = TRAIN, 2 = RUN.
- `underrun_cnt`, out, 16: count of idle substitutions, saturating.

## Operation
State machine:
- **HOLD**
  - Entered at reset.
  - Data lanes carry `TRAIN_PATT`.
  - After `HOLD_LEN` cycles, goes to TRAIN.
- **TRAIN**
  - A counter runs from 0 to `TRAIN_LEN`-1; data lanes carry the training word.
  - At terminal count, goes to RUN.
  - If `train_req`=1 in any TRAIN cycle, the counter restarts at 0.
- **RUN**
  - Each cycle: if the FIFO is non-empty, pop one entry to the data lanes.
  - Otherwise send `IDLE_WORD` on all data lanes and increment `underrun_cnt` (saturates at 16'hFFFF).
  - `train_req`=1 moves the machine to TRAIN on the next edge.

FIFO rules:
- A push occurs when `s_valid & s_ready`. `s_ready` = !full in every state, including HOLD and TRAIN.
- FIFO contents survive retraining.
- There is no bypass: a word pushed into an empty FIFO cannot pop in the same cycle.
- Push and pop in the same cycle are legal when the FIFO is neither full nor empty; the occupancy is unchanged.
- While full, `s_ready`=0, so no push is attempted.

Output:
- `tx_clk` = `CLK_PATT` on every lane in every state.
- Final output XOR: each lane whose swap-mask bit is 1 has all 7 bits inverted. This applies to training, idle, data and clock words alike.

## Timing
Reset values (while `resetn`=0):
- `link_state`=0, counters 0, FIFO empty, `underrun_cnt`=0.
- `s_ready`=0 while in reset, 1 from the first edge after release.
- `tx_dat` = `TRAIN_PATT` per lane XOR mask.
- `tx_clk` = `CLK_PATT` per lane XOR mask.

Other rules:
- All outputs are registered.
- Latency: a word pushed in cycle t with the FIFO empty in RUN appears on `tx_dat` in cycle t+2.
- From reset release, HOLD lasts `HOLD_LEN` cycles and TRAIN lasts `TRAIN_LEN` cycles. The first RUN output appears at cycle `HOLD_LEN`+`TRAIN_LEN`+1.
- `link_state` changes on the same edge at which `tx_dat` begins carrying the new state's words.
- An asynchronous reset in mid-stream empties the FIFO immediately; words not yet sent are lost.

## Configuration
`TX_PRBS_TRAIN_EN`:
- Defined: in TRAIN, each data lane sends successive 7-bit chunks of PRBS-7 (x^7+x^6+1). The generator is seeded to 7'h7F at every entry to TRAIN, and all lanes carry identical words before the swap mask is applied. HOLD still sends `TRAIN_PATT`.
- Undefined: TRAIN sends `TRAIN_PATT`, and no PRBS logic is generated.

## Test plan
- Reset release, N=1, D=4, defaults: `link_state` reads 0 for 16 cycles, then 1 for 256 cycles, then 2. `tx_clk` = 7'b1100011 throughout.
- In RUN, push 28'h0ABCDEF in cycle t with the FIFO empty: `tx_dat`=28'h0ABCDEF in cycle t+2, `IDLE_WORD` before and after, and `underrun_cnt` increments on each idle cycle.
- Hold `s_valid`=1 during TRAIN: `s_ready` falls after 4 pushes. In RUN, the 4 words drain in order on consecutive cycles, and `s_ready` returns 1 the cycle after the first pop.
- Assert `train_req` for 1 cycle in RUN with 2 words queued: TRAIN for 256 cycles, then the 2 words are sent first, in order.
- With `TX_SWAP_MASK`=4'b0010 and `TX_CLK_SWAP_MASK`=1: lane 1 outputs ~`TRAIN_PATT` in TRAIN and `tx_clk`=7'b0011100.
- With `TX_PRBS_TRAIN_EN` defined: the first TRAIN word on each lane equals the first 7 PRBS-7 bits from seed 7'h7F, and the sequence repeats after 127 words.
